// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, forwards writeback data,
// detects load-use hazards and holds one operand bundle for EX under a
// valid/ready handshake. All state is reset synchronously by rst_n low.
module operand_fetch #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // decoded instruction in
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    // register file read port
    output logic [4:0]        rf_rr1,
    output logic [4:0]        rf_rr2,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    // writeback
    input  logic              wb_we,
    input  logic [4:0]        wb_wr,
    input  logic [XLEN-1:0]   wb_wd,
    // pending load in EX
    input  logic              ld_pend,
    input  logic [4:0]        ld_rd,
    input  logic              flush,
    // operand bundle out
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [15:0]       stall_cnt
);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   op1_q,   op1_d;
    logic [XLEN-1:0]   op2_q,   op2_d;
    logic [4:0]        rs1_q,   rs1_d;
    logic [4:0]        rs2_q,   rs2_d;
    logic [4:0]        rd_q,    rd_d;
    logic [XLEN-1:0]   imm_q,   imm_d;
    logic [XLEN-1:0]   pc_q,    pc_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [15:0]       cnt_q,   cnt_d;

    logic              wb_hit_nz;
    logic [XLEN-1:0]   op1_next, op2_next;
    logic              ld_haz;
    logic              accept;

    assign rf_rr1 = in_rs1;
    assign rf_rr2 = in_rs2;

    assign wb_hit_nz = wb_we && (wb_wr != 5'd0);

    // Resolve incoming operands: r0 forced to zero, then writeback forwarding
    always_comb begin
        op1_next = rf_rd1;
        op2_next = rf_rd2;
        if (in_rs1 == 5'd0)
            op1_next = '0;
        else if (wb_hit_nz && (wb_wr == in_rs1))
            op1_next = wb_wd;
        if (in_rs2 == 5'd0)
            op2_next = '0;
        else if (wb_hit_nz && (wb_wr == in_rs2))
            op2_next = wb_wd;
    end

    assign ld_haz   = ld_pend && (ld_rd != 5'd0) &&
                      ((ld_rd == in_rs1) || (ld_rd == in_rs2));
    assign in_ready = rst_n && !flush && !ld_haz && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Next-state for the output bundle and the stall counter
    always_comb begin
        valid_d = valid_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;

        // accept is already suppressed by flush through in_ready
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            op1_d   = op1_next;
            op2_d   = op2_next;
            rs1_d   = in_rs1;
            rs2_d   = in_rs2;
            rd_d    = in_rd;
            imm_d   = in_imm;
            pc_d    = in_pc;
            ctrl_d  = in_ctrl;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // held bundle picks up writebacks landing on its sources
            if (wb_hit_nz && (wb_wr == rs1_q))
                op1_d = wb_wd;
            if (wb_hit_nz && (wb_wr == rs2_q))
                op2_d = wb_wd;
        end

        if (in_valid && ld_haz && !flush && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_op1   = op1_q;
    assign out_op2   = op2_q;
    assign out_rs1   = rs1_q;
    assign out_rs2   = rs2_q;
    assign out_rd    = rd_q;
    assign out_imm   = imm_q;
    assign out_pc    = pc_q;
    assign out_ctrl  = ctrl_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch; the bench models the register file.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm, in_pc;
    logic [15:0] in_ctrl;
    logic [4:0]  rf_rr1, rf_rr2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_wr;
    logic [31:0] wb_wd;
    logic        ld_pend;
    logic [4:0]  ld_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [31:0] out_imm, out_pc;
    logic [15:0] out_ctrl;
    logic [15:0] stall_cnt;

    logic [31:0] rf [32];
    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    assign rf_rd1 = (rf_rr1 == 5'd0) ? 32'd0 : rf[rf_rr1];
    assign rf_rd2 = (rf_rr2 == 5'd0) ? 32'd0 : rf[rf_rr2];

    operand_fetch #(.XLEN(32), .CTRL_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_imm(in_imm), .in_pc(in_pc), .in_ctrl(in_ctrl),
        .rf_rr1(rf_rr1), .rf_rr2(rf_rr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd),
        .ld_pend(ld_pend), .ld_rd(ld_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_pc(out_pc), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance one edge and settle past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[1] = 32'h01; rf[3] = 32'h33; rf[5] = 32'h11;
        rf[6] = 32'h66; rf[7] = 32'h77;

        rst_n = 1'b0; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        in_imm = '0; in_pc = '0; in_ctrl = '0; wb_we = 1'b0; wb_wr = '0;
        wb_wd = '0; ld_pend = 1'b0; ld_rd = '0; flush = 1'b0; out_ready = 1'b1;

        // reset
        step(); step();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rst_op1", out_op1, 32'd0);
        check("rst_inready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_inready", {31'd0, in_ready}, 32'd1);

        // plain read
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd0; in_rd = 5'd9;
        in_imm = 32'h123; in_pc = 32'h1000; in_ctrl = 16'hBEEF;
        step();
        in_valid = 1'b0;
        check("rd_valid", {31'd0, out_valid}, 32'd1);
        check("rd_op1", out_op1, 32'h11);
        check("rd_op2", out_op2, 32'd0);
        check("rd_rd", {27'd0, out_rd}, 32'd9);
        check("rd_imm", out_imm, 32'h123);
        check("rd_pc", out_pc, 32'h1000);
        check("rd_ctrl", {16'd0, out_ctrl}, 32'hBEEF);
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_hold_op1", out_op1, 32'h11);

        // bypass, then r0 with wb to r0, back to back
        in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6;
        wb_we = 1'b1; wb_wr = 5'd5; wb_wd = 32'hAA;
        step();
        check("byp_op1", out_op1, 32'hAA);
        check("byp_op2", out_op2, 32'h66);
        in_rs1 = 5'd0; in_rs2 = 5'd6; wb_wr = 5'd0; wb_wd = 32'hBB;
        #1;
        check("b2b_inready", {31'd0, in_ready}, 32'd1);
        step();
        check("r0_valid", {31'd0, out_valid}, 32'd1);
        check("r0_op1", out_op1, 32'd0);
        check("r0_op2", out_op2, 32'h66);
        in_valid = 1'b0; wb_we = 1'b0;
        step();
        check("idle2_valid", {31'd0, out_valid}, 32'd0);

        // load-use stall for three cycles
        in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd7; ld_pend = 1'b1; ld_rd = 5'd7;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("lu_inready", {31'd0, in_ready}, 32'd0);
            step();
            check("lu_valid", {31'd0, out_valid}, 32'd0);
        end
        check("lu_cnt", {16'd0, stall_cnt}, 32'd3);
        ld_pend = 1'b0;
        #1;
        check("lu_release", {31'd0, in_ready}, 32'd1);
        step();
        check("lu_acc_valid", {31'd0, out_valid}, 32'd1);
        check("lu_acc_op2", out_op2, 32'h77);
        check("lu_cnt_hold", {16'd0, stall_cnt}, 32'd3);

        // backpressure refresh
        in_rs1 = 5'd3; in_rs2 = 5'd7; in_rd = 5'd2;
        step();
        check("bp_op1", out_op1, 32'h33);
        out_ready = 1'b0; in_rs1 = 5'd4;
        #1;
        check("bp_inready", {31'd0, in_ready}, 32'd0);
        step();
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_rs1", {27'd0, out_rs1}, 32'd3);
        wb_we = 1'b1; wb_wr = 5'd3; wb_wd = 32'h55;
        step();
        check("ref_op1", out_op1, 32'h55);
        check("ref_op2", out_op2, 32'h77);
        check("ref_valid", {31'd0, out_valid}, 32'd1);
        check("ref_rd", {27'd0, out_rd}, 32'd2);
        wb_wr = 5'd7; wb_wd = 32'h99;
        step();
        check("ref2_op2", out_op2, 32'h99);
        check("ref2_op1", out_op1, 32'h55);
        wb_we = 1'b0;

        // flush colliding with accept
        out_ready = 1'b1; flush = 1'b1; in_rs1 = 5'd5;
        #1;
        check("fl_inready", {31'd0, in_ready}, 32'd0);
        step();
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_nocap", {27'd0, out_rs1}, 32'd3);
        // hazard under flush does not count
        ld_pend = 1'b1; ld_rd = 5'd5;
        step();
        check("fl_cnt", {16'd0, stall_cnt}, 32'd3);
        ld_pend = 1'b0; flush = 1'b0;

        // reset while holding
        step();
        check("rh_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0; out_ready = 1'b0;
        step();
        check("rh_hold", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rh_inready", {31'd0, in_ready}, 32'd0);
        step();
        check("rh_valid0", {31'd0, out_valid}, 32'd0);
        check("rh_cnt", {16'd0, stall_cnt}, 32'd0);
        check("rh_op1", out_op1, 32'd0);
        rst_n = 1'b1; in_valid = 1'b1; in_rs1 = 5'd5; out_ready = 1'b1;
        step();
        check("resume_valid", {31'd0, out_valid}, 32'd1);
        check("resume_op1", out_op1, 32'h11);
        in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
